// File: rtl/line_buf_writer.sv
// ---------------------------------------------------------------------------
// line_buf_writer
//   Write-side controller for a circular pixel line buffer held in port A of
//   a true-dual-port RAM. Packs a valid/ready pixel stream into NUM_LINES rows
//   of LINE_LEN pixels, pulses line_done per completed row and frame_done on
//   the last row of a frame, counts rows not yet released by the reader and
//   stalls upstream while every row is occupied.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   s_valid/s_ready upstream handshake; s_data pixel, s_sof start-of-frame
//   line_release    reader freed the oldest row (1-cycle pulse)
//   ram_en/ram_we   RAM port A enable / write enable (registered)
//   ram_addr/ram_di RAM port A address {wr_line, col} and write data
//   line_done       row written, aligned with its last RAM write
//   frame_done      last row of the frame written, aligned with line_done
//   lines_filled    rows written and not yet released
//   err_sof         sticky: sof accepted in the middle of a frame
//   err_release     sticky: release while no row was filled
// ---------------------------------------------------------------------------
module line_buf_writer #(
   parameter int WIDTH_G    = 32,
   parameter int LINE_LEN   = 64,
   parameter int NUM_LINES  = 4,
   parameter int COLW       = 6,
   parameter int LINEW      = 2,
   parameter int ADDRWIDTH  = 8,
   parameter int FRAME_ROWS = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WIDTH_G-1:0]   s_data,
   input  logic                 s_sof,
   input  logic                 line_release,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDRWIDTH-1:0] ram_addr,
   output logic [WIDTH_G-1:0]   ram_di,
   output logic                 line_done,
   output logic                 frame_done,
   output logic [LINEW:0]       lines_filled,
   output logic                 err_sof,
   output logic                 err_release
);

   localparam int ROWW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
   localparam logic [COLW-1:0]  COL_LAST  = COLW'(LINE_LEN - 1);
   localparam logic [ROWW-1:0]  ROW_LAST  = ROWW'(FRAME_ROWS - 1);
   localparam logic [LINEW:0]   FILL_FULL = (LINEW+1)'(NUM_LINES);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_WAIT_FREE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [COLW-1:0]     col_q, col_d;
   logic [LINEW-1:0]    line_q, line_d;
   logic [ROWW-1:0]     row_q, row_d;
   logic [LINEW:0]      filled_q, filled_d;

   logic                ram_en_q;
   logic [ADDRWIDTH-1:0] ram_addr_q;
   logic [WIDTH_G-1:0]  ram_di_q;
   logic                line_done_q, frame_done_q, err_sof_q, err_release_q;

   logic                s_ready_s, accept_s, row_end_s, frame_end_s, rel_ok_s;

   // Upstream ready: IDLE only opens for a start-of-frame beat with room left.
   always_comb begin
      s_ready_s = 1'b0;
      case (state_q)
         ST_IDLE:      s_ready_s = s_valid && s_sof && (filled_q < FILL_FULL);
         ST_WRITE:     s_ready_s = 1'b1;
         ST_WAIT_FREE: s_ready_s = 1'b0;
         default:      s_ready_s = 1'b0;
      endcase
   end

   assign s_ready     = s_ready_s;
   assign accept_s    = s_valid && s_ready_s;
   assign row_end_s   = accept_s && (col_q == COL_LAST);
   assign frame_end_s = row_end_s && (row_q == ROW_LAST);
   // A release with nothing filled is an error and must not underflow the count.
   assign rel_ok_s    = line_release && (filled_q != {(LINEW+1){1'b0}});

   // Occupied-row count: completion and release in the same cycle cancel.
   always_comb begin
      filled_d = filled_q;
      if (row_end_s && !rel_ok_s) begin
         filled_d = filled_q + (LINEW+1)'(1);
      end else if (!row_end_s && rel_ok_s) begin
         filled_d = filled_q - (LINEW+1)'(1);
      end else begin
         filled_d = filled_q;
      end
   end

   // Next-state logic for the FSM and the column/line/row counters.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      line_d  = line_q;
      row_d   = row_q;
      if (accept_s) begin
         if (row_end_s) begin
            col_d  = {COLW{1'b0}};
            line_d = line_q + LINEW'(1);
            if (frame_end_s) begin
               row_d = {ROWW{1'b0}};
            end else begin
               row_d = row_q + ROWW'(1);
            end
         end else begin
            col_d = col_q + COLW'(1);
         end
      end else begin
         col_d = col_q;
      end
      case (state_q)
         ST_IDLE, ST_WRITE: begin
            // Frame end wins over the full-buffer stall.
            if (frame_end_s) begin
               state_d = ST_IDLE;
            end else if (row_end_s && (filled_d == FILL_FULL)) begin
               state_d = ST_WAIT_FREE;
            end else if (accept_s) begin
               state_d = ST_WRITE;
            end else begin
               state_d = state_q;
            end
         end
         ST_WAIT_FREE: begin
            if (rel_ok_s) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_WAIT_FREE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         col_q    <= {COLW{1'b0}};
         line_q   <= {LINEW{1'b0}};
         row_q    <= {ROWW{1'b0}};
         filled_q <= {(LINEW+1){1'b0}};
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         line_q   <= line_d;
         row_q    <= row_d;
         filled_q <= filled_d;
      end
   end

   // Registered RAM port, row/frame pulses and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_en_q      <= 1'b0;
         ram_addr_q    <= {ADDRWIDTH{1'b0}};
         ram_di_q      <= {WIDTH_G{1'b0}};
         line_done_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         err_sof_q     <= 1'b0;
         err_release_q <= 1'b0;
      end else begin
         ram_en_q     <= accept_s;
         line_done_q  <= row_end_s;
         frame_done_q <= frame_end_s;
         if (accept_s) begin
            ram_addr_q <= {line_q, col_q};
            ram_di_q   <= s_data;
         end
         if (accept_s && s_sof && (state_q != ST_IDLE)) begin
            err_sof_q <= 1'b1;
         end
         if (line_release && !rel_ok_s) begin
            err_release_q <= 1'b1;
         end
      end
   end

   assign ram_en       = ram_en_q;
   assign ram_we       = ram_en_q;
   assign ram_addr     = ram_addr_q;
   assign ram_di       = ram_di_q;
   assign line_done    = line_done_q;
   assign frame_done   = frame_done_q;
   assign lines_filled = filled_q;
   assign err_sof      = err_sof_q;
   assign err_release  = err_release_q;

endmodule

// File: tb/tb_line_buf_writer.sv
module tb_line_buf_writer;

   localparam int W    = 32;
   localparam int LL   = 64;
   localparam int NL   = 4;
   localparam int ROWS = 48;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  s_data = '0;
   logic          s_sof = 1'b0;
   logic          line_release = 1'b0;
   logic          ram_en, ram_we;
   logic [7:0]    ram_addr;
   logic [W-1:0]  ram_di;
   logic          line_done, frame_done;
   logic [2:0]    lines_filled;
   logic          err_sof, err_release;

   int checks = 0;
   int failures = 0;

   // behavioural reference: frame/pixel bookkeeping
   int    m_filled, m_pix, m_row, m_lines_total;
   bit    m_active, m_stall, m_err_sof, m_err_rel, m_en, m_ld, m_fd;
   int    m_addr;
   logic [W-1:0] m_di;
   int    dut_ld_count;
   bit    dut_fd_seen;

   always #5 clk = ~clk;

   line_buf_writer dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sof(s_sof), .line_release(line_release),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
      .line_done(line_done), .frame_done(frame_done), .lines_filled(lines_filled),
      .err_sof(err_sof), .err_release(err_release)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_filled = 0; m_pix = 0; m_row = 0; m_lines_total = 0;
      m_active = 0; m_stall = 0; m_err_sof = 0; m_err_rel = 0;
      m_en = 0; m_ld = 0; m_fd = 0; m_addr = 0; m_di = '0;
   endtask

   // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      s_valid = 1'b0; s_sof = 1'b0; line_release = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_di", ram_di, 0);
      check("rst_line_done", line_done, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_lines_filled", lines_filled, 0);
      check("rst_err_sof", err_sof, 0);
      check("rst_err_release", err_release, 0);
      check("rst_s_ready", s_ready, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive, check ready, advance the model, check registered outputs.
   task automatic cycle(input bit v, input logic [W-1:0] d, input bit sof, input bit rel,
                        output bit rdy);
      bit exp_ready, acc, rel_ok, was_active;
      @(negedge clk);
      s_valid = v; s_data = d; s_sof = sof; line_release = rel;
      #1;
      exp_ready = m_active ? !m_stall : (v && sof && (m_filled < NL));
      rdy = s_ready;
      check("s_ready", s_ready, exp_ready);
      acc = v && exp_ready;
      rel_ok = rel && (m_filled > 0);
      if (rel && m_filled == 0) m_err_rel = 1;
      was_active = m_active;
      m_en = acc; m_ld = 0; m_fd = 0;
      if (acc) begin
         m_addr = (m_lines_total % NL) * LL + m_pix;
         m_di = d;
         if (was_active && sof) m_err_sof = 1;
         m_active = 1;
         m_pix++;
         if (m_pix == LL) begin
            m_pix = 0; m_ld = 1; m_lines_total++;
            if (m_row == ROWS - 1) begin
               m_fd = 1; m_active = 0; m_row = 0;
            end else begin
               m_row++;
            end
         end
      end
      m_filled = m_filled + (m_ld ? 1 : 0) - (rel_ok ? 1 : 0);
      if (m_stall && rel_ok) m_stall = 0;
      if (m_ld && m_active && m_filled == NL) m_stall = 1;
      @(posedge clk);
      #1;
      check("ram_en", ram_en, m_en);
      check("ram_we", ram_we, m_en);
      check("ram_addr", ram_addr, m_addr);
      check("ram_di", ram_di, m_di);
      check("line_done", line_done, m_ld);
      check("frame_done", frame_done, m_fd);
      check("lines_filled", lines_filled, m_filled);
      check("err_sof", err_sof, m_err_sof);
      check("err_release", err_release, m_err_rel);
      if (line_done) dut_ld_count++;
      if (frame_done) dut_fd_seen = 1;
   endtask

   task automatic run_beats(input int n, input bit sof_first, input bit rel_last);
      bit r;
      for (int i = 0; i < n; i++)
         cycle(1'b1, $urandom, sof_first && (i == 0), rel_last && (i == n - 1), r);
   endtask

   typedef struct {
      bit v; bit sof; bit rel;
      bit exp_ready; bit exp_err_rel; int exp_filled;
   } vec_t;
   vec_t tbl[5];

   initial begin
      bit r;
      int n;
      int exp_addr;
      tbl[0] = '{v:1'b0, sof:1'b0, rel:1'b0, exp_ready:1'b0, exp_err_rel:1'b0, exp_filled:0};
      tbl[1] = '{v:1'b1, sof:1'b0, rel:1'b0, exp_ready:1'b0, exp_err_rel:1'b0, exp_filled:0};
      tbl[2] = '{v:1'b0, sof:1'b1, rel:1'b0, exp_ready:1'b0, exp_err_rel:1'b0, exp_filled:0};
      tbl[3] = '{v:1'b0, sof:1'b0, rel:1'b1, exp_ready:1'b0, exp_err_rel:1'b1, exp_filled:0};
      tbl[4] = '{v:1'b1, sof:1'b0, rel:1'b0, exp_ready:1'b0, exp_err_rel:1'b1, exp_filled:0};

      model_reset();
      do_reset();

      // idle behaviour and release-at-zero error
      for (int i = 0; i < 5; i++) begin
         cycle(tbl[i].v, $urandom, tbl[i].sof, tbl[i].rel, r);
         check("tbl_ready", r, tbl[i].exp_ready);
         check("tbl_err_release", err_release, tbl[i].exp_err_rel);
         check("tbl_lines_filled", lines_filled, tbl[i].exp_filled);
      end

      do_reset();
      dut_ld_count = 0; dut_fd_seen = 0;

      // first row, no stalls
      run_beats(LL, 1'b1, 1'b0);
      check("row0_filled", lines_filled, 1);
      check("row0_last_addr", ram_addr, LL - 1);
      check("row0_line_done", line_done, 1);

      // fill the buffer, expect stall
      run_beats(3 * LL, 1'b0, 1'b0);
      check("full_filled", lines_filled, NL);
      cycle(1'b1, $urandom, 1'b0, 1'b0, r);
      check("stall_ready", r, 0);
      cycle(1'b1, $urandom, 1'b0, 1'b1, r);
      check("stall_release_ready", r, 0);
      check("after_release_filled", lines_filled, NL - 1);
      cycle(1'b1, $urandom, 1'b0, 1'b0, r);
      check("wrap_ready", r, 1);
      check("wrap_addr", ram_addr, 0);
      check("wrap_en", ram_en, 1);
      run_beats(LL - 1, 1'b0, 1'b0);
      check("refull_filled", lines_filled, NL);

      // release coinciding with row completion
      cycle(1'b0, $urandom, 1'b0, 1'b1, r);
      run_beats(LL, 1'b0, 1'b1);
      check("coincide_filled", lines_filled, NL - 1);
      cycle(1'b1, $urandom, 1'b0, 1'b0, r);
      check("coincide_no_stall", r, 1);

      // remainder of the frame with random valid and release
      n = 0;
      while (!dut_fd_seen && n < 20000) begin
         cycle($urandom_range(0, 3) != 0, $urandom, 1'b0,
               (m_filled > 0) && ($urandom_range(0, 2) == 0), r);
         n++;
      end
      check("frame_done_seen", dut_fd_seen, 1);
      check("frame_line_done_count", dut_ld_count, ROWS);

      // after the frame, non-sof beats are refused
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, $urandom, 1'b0, 1'b0, r);
         check("post_frame_ready", r, 0);
         check("post_frame_no_write", ram_en, 0);
      end

      // drain, new frame, sof in the middle of a row
      n = 0;
      while (m_filled > 0 && n < 16) begin
         cycle(1'b0, $urandom, 1'b0, 1'b1, r);
         n++;
      end
      check("drained", lines_filled, 0);
      run_beats(31, 1'b1, 1'b0);
      exp_addr = (m_lines_total % NL) * LL + 31;
      cycle(1'b1, $urandom, 1'b1, 1'b0, r);
      check("mid_sof_err", err_sof, 1);
      check("mid_sof_addr", ram_addr, exp_addr);

      // reset in the middle of row 2, then restart
      do_reset();
      run_beats(2 * LL + 30, 1'b1, 1'b0);
      check("pre_reset_addr", ram_addr, 2 * LL + 29);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, $urandom, 1'b0, 1'b0, r);
         check("post_reset_no_write", ram_en, 0);
      end
      run_beats(1, 1'b1, 1'b0);
      check("restart_addr", ram_addr, 0);
      check("restart_en", ram_en, 1);
      run_beats(5, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
